// File: rtl/mac_rx.sv
// mac_rx: RMII receive MAC.
//   Samples one dibit per clk on rx1/rx0 while crs_dv is high. Strips the preamble and SFD.
//   Reassembles bytes with the LSB dibit first and streams them out with no backpressure.
//   Checks the FCS (reflected CRC-32) and the frame length, then reports one status per frame.
// Ports:
//   clk        RMII 50 MHz reference clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   rx0, rx1   RXD0 / RXD1 (dibit bits 0 / 1)
//   crs_dv     carrier sense / data valid
//   enable     0 holds the receiver in IDLE (an in-progress frame is aborted)
//   out_data   received byte (dst mac first, FCS bytes included)
//   out_valid  1-cycle strobe qualifying out_data
//   out_sof    with out_valid on the first byte of a frame
//   out_end    1-cycle strobe, frame finished or aborted
//   out_ok     with out_end: FCS good and MIN_LEN <= len <= MAX_LEN
//   out_len    with out_end: number of complete bytes received
//   debug      [2:0] state, [7:3] good frames mod 32, [12:8] bad frames mod 32
module mac_rx #(
  parameter int MIN_PREAMBLE = 10,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx0,
  input  logic        rx1,
  input  logic        crs_dv,
  input  logic        enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_end,
  output logic        out_ok,
  output logic [10:0] out_len,
  output logic [15:0] debug
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_DROP     = 3'd3;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value after running a frame with a correct FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [4:0]  PRE_MIN = 5'(MIN_PREAMBLE);
  localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

  logic [1:0]  dibit_d;
  logic        crs_d;
  logic        crs_dd;
  logic [2:0]  state;
  logic [4:0]  pcnt;
  logic [5:0]  shift;     // the three earlier dibits of the byte being assembled
  logic [1:0]  dcnt;
  logic [10:0] len;
  logic [31:0] crc;
  logic [4:0]  ok_cnt;
  logic [4:0]  err_cnt;

  logic        crs_gone;
  logic [7:0]  byte_in;
  logic        frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  // Carrier is only considered gone after two low samples, so the RMII
  // end-of-frame toggling of crs_dv does not truncate the frame.
  assign crs_gone   = !crs_d && !crs_dd;
  assign byte_in    = {dibit_d, shift};
  assign frame_good = (crc == CRC_RESIDUE) && (len >= LEN_MIN) && (len <= LEN_MAX);
  assign debug      = {3'd0, err_cnt, ok_cnt, state};

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would chain them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dibit_d   <= 2'd0;
      crs_d     <= 1'b0;
      crs_dd    <= 1'b0;
      state     <= ST_IDLE;
      pcnt      <= 5'd0;
      shift     <= 6'd0;
      dcnt      <= 2'd0;
      len       <= 11'd0;
      crc       <= 32'd0;
      ok_cnt    <= 5'd0;
      err_cnt   <= 5'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_end   <= 1'b0;
      out_ok    <= 1'b0;
      out_len   <= 11'd0;
    end else begin
      dibit_d   <= {rx1, rx0};
      crs_d     <= crs_dv;
      crs_dd    <= crs_d;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_end   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable && crs_d) begin
            state <= ST_PREAMBLE;
            pcnt  <= 5'd0;
          end
        end

        ST_PREAMBLE: begin
          if (!enable || crs_gone) begin
            state <= ST_IDLE;
          end else if (crs_d) begin
            case (dibit_d)
              2'b01: if (pcnt != 5'd31) pcnt <= pcnt + 5'd1;
              2'b11: begin
                if (pcnt >= PRE_MIN) begin
                  state <= ST_DATA;
                  crc   <= CRC_INIT;
                  dcnt  <= 2'd0;
                  len   <= 11'd0;
                end else begin
                  state <= ST_DROP;
                end
              end
              2'b10:   state <= ST_DROP;
              default: ;
            endcase
          end
        end

        ST_DATA: begin
          if (!enable) begin
            out_end <= 1'b1;
            out_ok  <= 1'b0;
            out_len <= len;
            err_cnt <= err_cnt + 5'd1;
            state   <= ST_IDLE;
          end else if (len > LEN_MAX) begin
            // Byte MAX_LEN+1 went out last cycle; abort here so out_end
            // never coincides with out_valid, and len stops short of wrapping.
            out_end <= 1'b1;
            out_ok  <= 1'b0;
            out_len <= len;
            err_cnt <= err_cnt + 5'd1;
            state   <= ST_DROP;
          end else if (crs_gone) begin
            // Any partial byte left in shift is dropped without error.
            out_end <= 1'b1;
            out_ok  <= frame_good;
            out_len <= len;
            if (frame_good) ok_cnt  <= ok_cnt + 5'd1;
            else            err_cnt <= err_cnt + 5'd1;
            state   <= ST_IDLE;
          end else begin
            // The first low crs_d sample still carries data.
            shift <= {dibit_d, shift[5:2]};
            dcnt  <= dcnt + 2'd1;
            if (dcnt == 2'd3) begin
              out_data  <= byte_in;
              out_valid <= 1'b1;
              out_sof   <= (len == 11'd0);
              len       <= len + 11'd1;
              crc       <= crc_byte(crc, byte_in);
            end
          end
        end

        ST_DROP: begin
          if (!enable || crs_gone) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: randomized self-checking bench for mac_rx.
//   Frames are random payloads with an FCS computed bit-serially here; the expected
//   output stream, status and length come from that frame and the length rules.
module tb_mac_rx;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx0 = 1'b0;
  logic        rx1 = 1'b0;
  logic        crs_dv = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_end;
  logic        out_ok;
  logic [10:0] out_len;
  logic [15:0] debug;

  mac_rx #(.MIN_PREAMBLE(10), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rx0(rx0), .rx1(rx1), .crs_dv(crs_dv), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_end(out_end),
    .out_ok(out_ok), .out_len(out_len), .debug(debug)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] frame[$];     // bytes on the wire after the SFD
  logic [2:0] stream[$];    // {crs_dv, rx1, rx0} per clk
  int         mark_cyc;
  int         ok_frames = 0;
  int         err_frames = 0;

  // Monitor, sampling away from the active edge.
  logic [7:0] got[$];
  bit         got_sof[$];
  int         end_cnt = 0;
  int         both_cnt = 0;
  int         first_v_cyc = -1;
  bit         last_ok;
  int         last_len;

  always @(negedge clk) begin
    if (out_valid) begin
      if (got.size() == 0) first_v_cyc = cyc;
      got.push_back(out_data);
      got_sof.push_back(out_sof);
    end
    if (out_end) begin
      end_cnt++;
      last_ok  = out_ok;
      last_len = int'(out_len);
    end
    if (out_valid && out_end) both_cnt++;
  end

  task automatic clear_mon();
    got.delete();
    got_sof.delete();
    end_cnt = 0;
    first_v_cyc = -1;
  endtask

  // Bit-serial reflected CRC-32 over frame[0 .. n-1], without final inversion.
  function automatic logic [31:0] crc_model(int n);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    logic        fb;
    for (int i = 0; i < n; i++) begin
      b = frame[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic bit model_ok();
    int n = frame.size();
    logic [31:0] fcs;
    if (n < MIN_LEN || n > MAX_LEN) return 1'b0;
    fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
    return crc_model(n - 4) == ~fcs;
  endfunction

  function automatic int first_diff(int n);
    for (int i = 0; i < n; i++)
      if (i >= got.size() || got[i] !== frame[i]) return i;
    return -1;
  endfunction

  function automatic int sof_count();
    int s = 0;
    foreach (got_sof[i]) s += int'(got_sof[i]);
    return s;
  endfunction

  task automatic make_frame(int payload_len);
    logic [31:0] fcs;
    frame.delete();
    for (int i = 0; i < payload_len; i++) frame.push_back(8'($urandom));
    fcs = ~crc_model(payload_len);
    for (int k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
  endtask

  task automatic build_stream(int pre, bit toggle);
    int total = frame.size() * 4;
    int j = 0;
    logic [7:0] b;
    logic crs;
    stream.delete();
    for (int i = 0; i < pre; i++) stream.push_back(3'b101);
    stream.push_back(3'b111);
    foreach (frame[i]) begin
      b = frame[i];
      for (int k = 0; k < 4; k++) begin
        crs = 1'b1;
        if (toggle && j >= total - 16) crs = ((j - (total - 16)) % 2 == 1);
        stream.push_back({crs, b[2*k +: 2]});
        j++;
      end
    end
    stream.push_back(3'b000);
    stream.push_back(3'b000);
  endtask

  task automatic drive_stream(int mark, int limit);
    for (int i = 0; i < stream.size() && i < limit; i++) begin
      @(negedge clk);
      {crs_dv, rx1, rx0} = stream[i];
      if (i == mark) mark_cyc = cyc;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      {crs_dv, rx1, rx0} = 3'b000;
    end
  endtask

  // Sends the current frame and checks bytes, status and length against the model.
  task automatic run_frame(string name, int pre, bit toggle);
    int  exp_n  = (frame.size() > MAX_LEN + 1) ? MAX_LEN + 1 : frame.size();
    bit  exp_ok = model_ok();
    int  d;
    clear_mon();
    build_stream(pre, toggle);
    drive_stream(pre + 4, stream.size());
    idle(8);
    if (exp_ok) ok_frames++; else err_frames++;
    n_cmp++;
    if (got.size() !== exp_n) begin
      n_bad++; $display("FAIL %s byte_count: got %0d want %0d", name, got.size(), exp_n);
    end
    d = first_diff(exp_n);
    n_cmp++;
    if (d != -1) begin
      n_bad++; $display("FAIL %s bytes: first differing index %0d", name, d);
    end
    n_cmp++;
    if (end_cnt !== 1 || last_ok !== exp_ok || last_len !== exp_n) begin
      n_bad++;
      $display("FAIL %s status: ends %0d ok %0d len %0d, want ends 1 ok %0d len %0d",
               name, end_cnt, last_ok, last_len, exp_ok, exp_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_data, out_valid, out_sof, out_end, out_ok, out_len, debug} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: data %h v %b sof %b end %b ok %b len %0d debug %h want all 0",
               out_data, out_valid, out_sof, out_end, out_ok, out_len, debug);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    make_frame(60);
    run_frame("good", 31, 1'b0);
    n_cmp++;
    if (got_sof.size() == 0 || got_sof[0] !== 1'b1 || sof_count() != 1) begin
      n_bad++; $display("FAIL good sof: count %0d want 1 on byte 0", sof_count());
    end
    n_cmp++;
    if (first_v_cyc - mark_cyc != 2) begin
      n_bad++; $display("FAIL good latency: got %0d clk want 2", first_v_cyc - mark_cyc);
    end
  endtask

  task automatic test_bad_fcs();
    int  idx;
    make_frame(60);
    idx = $urandom_range(0, 59);
    frame[idx] = frame[idx] ^ (8'd1 << $urandom_range(0, 7));
    run_frame("bad_fcs", 31, 1'b0);
  endtask

  task automatic test_end_toggle();
    make_frame(60);
    run_frame("end_toggle", 31, 1'b1);
  endtask

  task automatic test_short_preamble();
    make_frame(60);
    clear_mon();
    build_stream(4, 1'b0);
    drive_stream(-1, stream.size());
    idle(6);
    n_cmp++;
    if (got.size() != 0 || end_cnt != 0) begin
      n_bad++; $display("FAIL short_pre: got %0d bytes %0d ends want 0 0", got.size(), end_cnt);
    end
    make_frame(60 + $urandom_range(0, 20));
    run_frame("after_short_pre", 31, 1'b0);
  endtask

  task automatic test_length_limits();
    make_frame(1596);
    run_frame("overlong", 31, 1'b0);
    make_frame(36);
    run_frame("runt", 31, 1'b0);
  endtask

  task automatic test_reset_mid();
    make_frame(60);
    clear_mon();
    build_stream(31, 1'b0);
    drive_stream(-1, 32 + 80 + 2);
    @(negedge clk);
    rst_n = 1'b0;
    crs_dv = 1'b0;
    #1;
    ok_frames = 0;
    err_frames = 0;
    n_cmp++;
    if ({out_data, out_valid, out_sof, out_end, out_ok, out_len, debug} !== '0) begin
      n_bad++; $display("FAIL reset_mid outputs: debug %h len %0d want 0", debug, out_len);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    n_cmp++;
    if (end_cnt != 0 || got.size() != 20) begin
      n_bad++; $display("FAIL reset_mid: ends %0d bytes %0d want 0 20", end_cnt, got.size());
    end
    make_frame(60 + $urandom_range(0, 40));
    run_frame("after_reset", 31, 1'b0);
  endtask

  task automatic test_enable_mid();
    make_frame(60);
    clear_mon();
    build_stream(31, 1'b0);
    drive_stream(-1, 32 + 80 + 2);
    @(negedge clk);
    enable = 1'b0;
    {crs_dv, rx1, rx0} = {1'b1, 2'($urandom)};
    repeat (4) begin
      @(negedge clk);
      {crs_dv, rx1, rx0} = {1'b1, 2'($urandom)};
    end
    idle(4);
    enable = 1'b1;
    idle(4);
    err_frames++;
    n_cmp++;
    if (end_cnt != 1 || last_ok !== 1'b0 || last_len != 20 || got.size() != 20) begin
      n_bad++;
      $display("FAIL enable_mid: ends %0d ok %0d len %0d bytes %0d want 1 0 20 20",
               end_cnt, last_ok, last_len, got.size());
    end
    make_frame(60);
    run_frame("after_enable", 31, 1'b0);
  endtask

  task automatic test_debug(string name);
    logic [15:0] exp_dbg;
    exp_dbg = {3'd0, 5'(err_frames), 5'(ok_frames), 3'd0};
    n_cmp++;
    if (debug !== exp_dbg) begin
      n_bad++; $display("FAIL debug_%s: got %h want %h", name, debug, exp_dbg);
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++; $display("FAIL valid_end_overlap: got %0d cycles want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_end_toggle();
    test_short_preamble();
    test_debug("pre_limits");
    test_length_limits();
    test_debug("post_limits");
    test_reset_mid();
    test_enable_mid();
    test_debug("final");
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
